// File: rtl/mem_stage_ld_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ld_pkg
//  Purpose  : Shared definitions for the MEM load stage: stall-vector bit
//             indices, Stop/NoStop levels, load-size encodings, the load FSM
//             state type and helpers that derive bus widths from parameters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_ld_pkg;

   // Stall vector bit owned by this stage and by the following WB stage.
   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   // Load access size encodings.
   localparam logic [1:0] LD_BYTE  = 2'b00;
   localparam logic [1:0] LD_HALF  = 2'b01;
   localparam logic [1:0] LD_WORD  = 2'b10;
   localparam logic [1:0] LD_DWORD = 2'b11;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_WAIT = 2'd1,
      LD_DONE = 2'd2
   } ld_state_t;

   // {valid, pc, rf_we, rf_waddr, rf_wdata}
   function automatic int wb_bus_w(input int pc_w, input int rf_aw, input int data_w);
      return 1 + pc_w + 1 + rf_aw + data_w;
   endfunction

   // {rf_we, rf_waddr, rf_wdata}
   function automatic int id_bus_w(input int rf_aw, input int data_w);
      return 1 + rf_aw + data_w;
   endfunction

   // Width of the byte offset within one data word.
   function automatic int off_w(input int data_w);
      return (data_w == 64) ? 3 : 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_ld_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ld_align
//  Purpose  : Combinational load-data lane select, sign/zero extension and
//             misalignment detection.
//  Ports    : rdata     in  DATA_W  raw word returned by the data SRAM
//             offset    in  OFF_W   byte offset of the access in the word
//             size      in  2       access size (byte/half/word/dword)
//             sign_ext  in  1       1 = sign-extend, 0 = zero-extend
//             data      out DATA_W  aligned, extended load data
//             misalign  out 1       offset illegal for size, or dword on 32b
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ld_align
   import mem_stage_ld_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]         rdata,
   input  logic [off_w(DATA_W)-1:0]  offset,
   input  logic [1:0]                size,
   input  logic                      sign_ext,
   output logic [DATA_W-1:0]         data,
   output logic                      misalign
);

   localparam int OFF_W = off_w(DATA_W);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] ext_b;
   logic [DATA_W-1:0] ext_h;
   logic [DATA_W-1:0] ext_w;

   // Move the addressed lane down to bit 0.
   assign shifted = rdata >> {offset, 3'b000};

   assign ext_b = {{(DATA_W-8){sign_ext & shifted[7]}},   shifted[7:0]};
   assign ext_h = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};

   // A word fills the whole datapath on 32-bit builds, so it needs no extension.
   generate
      if (DATA_W == 64) begin : g_word_w64
         assign ext_w = {{(DATA_W-32){sign_ext & shifted[31]}}, shifted[31:0]};
      end else begin : g_word_w32
         assign ext_w = shifted;
      end
   endgenerate

   always_comb begin
      data     = shifted;
      misalign = 1'b0;
      case (size)
         LD_BYTE: begin
            data = ext_b;
         end
         LD_HALF: begin
            data     = ext_h;
            misalign = offset[0];
         end
         LD_WORD: begin
            data     = ext_w;
            misalign = |offset[1:0];
         end
         default: begin
            // dword: only legal on a 64-bit datapath and at offset 0
            data     = shifted;
            misalign = (DATA_W != 64) || (|offset[OFF_W-1:0]);
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ld.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ld
//  Purpose  : MEM pipeline stage. Holds the EX/MEM register, waits for
//             variable-latency data-SRAM read responses (stalling the pipe),
//             aligns/extends load data and drives the WB and forwarding buses.
//  Ports    : clk, rst                 clock, async active-high reset
//             stall[STALL_W]           per-stage stall vector (1 = Stop)
//             flush                    discard the held instruction
//             ex_*                     instruction fields from EX
//             data_sram_rvalid/rdata   in-order read responses
//             mem_stall_req            load outstanding, stall stages 0..3
//             mem_misalign             held load misaligned / illegal size
//             mem_to_wb_bus            {valid, pc, rf_we, rf_waddr, rf_wdata}
//             mem_to_id                {rf_we, rf_waddr, rf_wdata}
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ld
   import mem_stage_ld_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 32,
   parameter int RF_AW   = 5,
   parameter int STALL_W = 6,
   parameter int DROP_W  = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [STALL_W-1:0]                       stall,
   input  logic                                     flush,
   input  logic                                     ex_valid,
   input  logic [PC_W-1:0]                          ex_pc,
   input  logic                                     ex_rf_we,
   input  logic [RF_AW-1:0]                         ex_rf_waddr,
   input  logic [DATA_W-1:0]                        ex_result,
   input  logic                                     ex_ld,
   input  logic [1:0]                               ex_ld_size,
   input  logic                                     ex_ld_signed,
   input  logic                                     data_sram_rvalid,
   input  logic [DATA_W-1:0]                        data_sram_rdata,
   output logic                                     mem_stall_req,
   output logic                                     mem_misalign,
   output logic [wb_bus_w(PC_W,RF_AW,DATA_W)-1:0]   mem_to_wb_bus,
   output logic [id_bus_w(RF_AW,DATA_W)-1:0]        mem_to_id
);

   localparam int               OFF_W    = off_w(DATA_W);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   // Held EX/MEM register
   logic              held_valid;
   logic [PC_W-1:0]   held_pc;
   logic              held_rf_we;
   logic [RF_AW-1:0]  held_rf_waddr;
   logic [DATA_W-1:0] held_result;
   logic              held_ld;
   logic [1:0]        held_ld_size;
   logic              held_ld_signed;

   ld_state_t         state;
   logic [DATA_W-1:0] ld_buf;
   logic [DROP_W-1:0] drop_cnt;

   logic              bubble;
   logic              capture;
   logic              resp_ok;
   logic              drop_inc;
   logic              drop_dec;
   logic [DATA_W-1:0] raw_data;
   logic [DATA_W-1:0] aligned_data;
   logic              align_misalign;
   logic [DATA_W-1:0] wdata;
   logic              rf_we_eff;
   logic              unused_stall;

   // Only the MEM and WB bits of the stall vector matter here.
   assign unused_stall = ^stall;

   assign bubble  = flush || (stall[STALL_MEM] == STOP && stall[STALL_WB] == NOSTOP);
   assign capture = (stall[STALL_MEM] == NOSTOP);

   // A response belongs to the held load only once all orphaned ones drained.
   assign resp_ok = (state == LD_WAIT) && data_sram_rvalid && (drop_cnt == '0);

   // An abandoned load leaves one response in flight, unless that response
   // is arriving in the very cycle the load is abandoned.
   assign drop_inc = bubble && (state == LD_WAIT) && !resp_ok;
   assign drop_dec = data_sram_rvalid && (drop_cnt != '0);

   // ---------------------------------------------------------------- register
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         held_valid     <= 1'b0;
         held_pc        <= '0;
         held_rf_we     <= 1'b0;
         held_rf_waddr  <= '0;
         held_result    <= '0;
         held_ld        <= 1'b0;
         held_ld_size   <= 2'b00;
         held_ld_signed <= 1'b0;
      end else if (capture) begin
         held_valid     <= ex_valid;
         held_pc        <= ex_pc;
         held_rf_we     <= ex_rf_we;
         held_rf_waddr  <= ex_rf_waddr;
         held_result    <= ex_result;
         held_ld        <= ex_ld;
         held_ld_size   <= ex_ld_size;
         held_ld_signed <= ex_ld_signed;
      end
   end

   // ---------------------------------------------------------------- load FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= LD_IDLE;
         ld_buf <= '0;
      end else begin
         if (resp_ok) begin
            ld_buf <= data_sram_rdata;
         end
         if (bubble) begin
            state <= LD_IDLE;
         end else if (capture) begin
            state <= (ex_valid && ex_ld) ? LD_WAIT : LD_IDLE;
         end else if (resp_ok) begin
            state <= LD_DONE;
         end
      end
   end

   // ---------------------------------------------------- discarded responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_inc && !drop_dec) begin
         if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end else if (drop_dec && !drop_inc) begin
         drop_cnt <= drop_cnt - 1'b1;
      end
   end

   // --------------------------------------------------------------- datapath
   // While waiting, the response is bypassed straight to the outputs.
   assign raw_data = (state == LD_WAIT) ? data_sram_rdata : ld_buf;

   mem_stage_ld_align #(
      .DATA_W (DATA_W)
   ) u_ld_align (
      .rdata    (raw_data),
      .offset   (held_result[OFF_W-1:0]),
      .size     (held_ld_size),
      .sign_ext (held_ld_signed),
      .data     (aligned_data),
      .misalign (align_misalign)
   );

   assign mem_stall_req = (state == LD_WAIT) && !(data_sram_rvalid && (drop_cnt == '0));
   assign mem_misalign  = held_valid && held_ld && align_misalign;

   assign wdata     = held_ld ? aligned_data : held_result;
   assign rf_we_eff = held_rf_we && !mem_misalign && !mem_stall_req;

   assign mem_to_wb_bus = {held_valid && !mem_stall_req, held_pc, rf_we_eff, held_rf_waddr, wdata};
   assign mem_to_id     = {rf_we_eff, held_rf_waddr, wdata};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ld.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_ld
//  Purpose  : Directed self-checking bench for mem_stage_ld (DATA_W = 32).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ld;

   localparam logic [5:0] RUN  = 6'b000000;
   localparam logic [5:0] HOLD = 6'b011111;   // MEM and WB both stopped
   localparam logic [5:0] BUBL = 6'b001000;   // MEM stopped, WB running

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = RUN;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_rf_we = 1'b0;
   logic [4:0]  ex_rf_waddr = '0;
   logic [31:0] ex_result = '0;
   logic        ex_ld = 1'b0;
   logic [1:0]  ex_ld_size = 2'b00;
   logic        ex_ld_signed = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        stall_req;
   logic        misalign;
   logic [70:0] wb_bus;
   logic [37:0] id_bus;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_ld dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_rf_we         (ex_rf_we),
      .ex_rf_waddr      (ex_rf_waddr),
      .ex_result        (ex_result),
      .ex_ld            (ex_ld),
      .ex_ld_size       (ex_ld_size),
      .ex_ld_signed     (ex_ld_signed),
      .data_sram_rvalid (rvalid),
      .data_sram_rdata  (rdata),
      .mem_stall_req    (stall_req),
      .mem_misalign     (misalign),
      .mem_to_wb_bus    (wb_bus),
      .mem_to_id        (id_bus)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_set(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] wa, input logic [31:0] res, input logic ld,
                         input logic [1:0] sz, input logic sg);
      ex_valid = v; ex_pc = pc; ex_rf_we = we; ex_rf_waddr = wa;
      ex_result = res; ex_ld = ld; ex_ld_size = sz; ex_ld_signed = sg;
   endtask

   task automatic ex_clear();
      ex_set(1'b0, '0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
   endtask

   initial begin
      // ---------------------------------------------------------- reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall_req", stall_req, 1'b0);
      check("rst_misalign",  misalign,  1'b0);
      check("rst_wb_bus",    wb_bus,    71'd0);
      check("rst_id_bus",    id_bus,    38'd0);
      tick();
      rst = 1'b0;

      // ---------------------------------------------------------- ALU op
      ex_set(1'b1, 32'h100, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 2'b00, 1'b0);
      tick();
      ex_clear();
      stall = BUBL;
      @(negedge clk);
      check("alu_wb_bus",    wb_bus,    {1'b1, 32'h100, 1'b1, 5'd5, 32'h0000_1234});
      check("alu_id_bus",    id_bus,    {1'b1, 5'd5, 32'h0000_1234});
      check("alu_stall_req", stall_req, 1'b0);
      tick();
      stall = RUN;
      @(negedge clk);
      check("mem_bubble_wb_bus", wb_bus, 71'd0);

      // ---------------------------------------------- LB signed, 2 waits
      ex_set(1'b1, 32'h104, 1'b1, 5'd7, 32'h0000_2003, 1'b1, 2'b00, 1'b1);
      tick();
      ex_clear();
      stall = HOLD;
      @(negedge clk);
      check("lb_wait1_stall_req", stall_req, 1'b1);
      check("lb_wait1_wb_valid",  wb_bus[70], 1'b0);
      check("lb_wait1_id_we",     id_bus[37], 1'b0);
      tick();
      @(negedge clk);
      check("lb_wait2_stall_req", stall_req, 1'b1);
      check("lb_wait2_id_we",     id_bus[37], 1'b0);
      tick();
      rvalid = 1'b1;
      rdata  = 32'h80AA_BBCC;
      stall  = RUN;
      @(negedge clk);
      check("lb_resp_stall_req", stall_req, 1'b0);
      check("lb_resp_wb_bus",    wb_bus, {1'b1, 32'h104, 1'b1, 5'd7, 32'hFFFF_FF80});
      check("lb_resp_id_bus",    id_bus, {1'b1, 5'd7, 32'hFFFF_FF80});
      tick();
      rvalid = 1'b0;

      // ---------------------------------------------- LHU, immediate rvalid
      ex_set(1'b1, 32'h108, 1'b1, 5'd9, 32'h0000_3002, 1'b1, 2'b01, 1'b0);
      tick();
      ex_clear();
      rvalid = 1'b1;
      rdata  = 32'h8001_0000;
      @(negedge clk);
      check("lhu_stall_req", stall_req, 1'b0);
      check("lhu_wb_bus",    wb_bus, {1'b1, 32'h108, 1'b1, 5'd9, 32'h0000_8001});
      tick();
      rvalid = 1'b0;

      // ---------------------------------------------- LW misaligned
      ex_set(1'b1, 32'h10C, 1'b1, 5'd10, 32'h0000_4002, 1'b1, 2'b10, 1'b0);
      tick();
      ex_clear();
      stall = HOLD;
      @(negedge clk);
      check("lw_mis_misalign",  misalign,  1'b1);
      check("lw_mis_stall_req", stall_req, 1'b1);
      tick();
      rvalid = 1'b1;
      rdata  = 32'h1122_3344;
      stall  = RUN;
      @(negedge clk);
      check("lw_mis_resp_stall_req", stall_req, 1'b0);
      check("lw_mis_wb_bus", wb_bus, {1'b1, 32'h10C, 1'b0, 5'd10, 32'h0000_1122});
      check("lw_mis_id_we",  id_bus[37], 1'b0);
      tick();
      rvalid = 1'b0;
      @(negedge clk);
      check("lw_mis_cleared", misalign, 1'b0);

      // ---------------------------------------------- flush during WAIT
      ex_set(1'b1, 32'h110, 1'b1, 5'd11, 32'h0000_5000, 1'b1, 2'b10, 1'b0);
      tick();
      ex_clear();
      stall = HOLD;
      @(negedge clk);
      check("fl_wait_stall_req", stall_req, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("fl_flushed_wb_bus",   wb_bus,    71'd0);
      check("fl_flushed_stall_req", stall_req, 1'b0);
      ex_set(1'b1, 32'h114, 1'b1, 5'd12, 32'h0000_6004, 1'b1, 2'b10, 1'b0);
      stall = RUN;
      tick();
      ex_clear();
      stall  = HOLD;
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("fl_stale_stall_req", stall_req, 1'b1);
      check("fl_stale_id_we",     id_bus[37], 1'b0);
      check("fl_stale_wb_valid",  wb_bus[70], 1'b0);
      tick();
      rdata = 32'h0000_0042;
      @(negedge clk);
      check("fl_new_stall_req", stall_req, 1'b0);
      check("fl_new_wb_bus",    wb_bus, {1'b1, 32'h114, 1'b1, 5'd12, 32'h0000_0042});

      // ---------------------------------------------- DONE held under stall
      tick();
      rvalid = 1'b0;
      rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("done_hold1_wb_bus", wb_bus, {1'b1, 32'h114, 1'b1, 5'd12, 32'h0000_0042});
      tick();
      @(negedge clk);
      check("done_hold2_id_bus", id_bus, {1'b1, 5'd12, 32'h0000_0042});

      // ---------------------------------------------- async reset, no edge
      #2;
      rst = 1'b1;
      #1;
      check("arst_wb_bus",    wb_bus,    71'd0);
      check("arst_id_bus",    id_bus,    38'd0);
      check("arst_stall_req", stall_req, 1'b0);
      tick();
      rst   = 1'b0;
      stall = RUN;

      // ---------------------------------------------- clean LW after reset
      ex_set(1'b1, 32'h118, 1'b1, 5'd13, 32'h0000_7000, 1'b1, 2'b10, 1'b0);
      tick();
      ex_clear();
      rvalid = 1'b1;
      rdata  = 32'hCAFE_F00D;
      @(negedge clk);
      check("post_rst_stall_req", stall_req, 1'b0);
      check("post_rst_wb_bus",    wb_bus, {1'b1, 32'h118, 1'b1, 5'd13, 32'hCAFE_F00D});
      tick();
      rvalid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_ld.md
# mem_stage_ld

Parametrised memory-access pipeline stage between EX and WB. Holds the EX/MEM pipeline register and tracks variable-latency data-SRAM read responses, stalling the pipe until each load returns. Aligns and sign/zero-extends byte, half, word (and dword when DATA_W=64) loads. Drives the MEM→WB bus and the MEM→ID forwarding bus, which is suppressed while a load is outstanding.

## Interface
Parameters:
- DATA_W, 32: datapath width; 32 or 64 only.
- PC_W, 32: PC width.
- RF_AW, 5: register-file address width.
- STALL_W, 6: stall bus width; bit 3 is this stage, bit 4 is WB.
- DROP_W, 2: width of the discarded-response counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  pipeline stall vector; 1 = Stop.
- flush  in  1  discard the instruction held in the stage.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_pc  in  PC_W  instruction PC.
- ex_rf_we, ex_rf_waddr  in  1, RF_AW  destination write enable/address.
- ex_result  in  DATA_W  ALU result or effective address.
- ex_ld  in  1  instruction is a load; its read request was issued in EX.
- ex_ld_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- ex_ld_signed  in  1  1 = sign-extend, 0 = zero-extend.
- data_sram_rvalid  in  1  read-data valid, one pulse per request, in order.
- data_sram_rdata  in  DATA_W  read data.
- mem_stall_req  out  1  load outstanding; request stall of stages 0..3.
- mem_misalign  out  1  held load is misaligned or has an illegal size.
- mem_to_wb_bus  out  1+PC_W+1+RF_AW+DATA_W  {valid, pc, rf_we, rf_waddr, rf_wdata}.
- mem_to_id  out  1+RF_AW+DATA_W  {rf_we, rf_waddr, rf_wdata}; forwarding.

## Operation
- Pipeline register update, in priority order:
  - rst → all fields 0.
  - flush → bubble (all 0).
  - stall[3]=1 and stall[4]=0 → bubble.
  - stall[3]=0 → capture ex_* fields.
  - Otherwise hold.
- Load FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
  - Capturing a valid load → WAIT. Capturing anything else, or a bubble → IDLE.
  - WAIT with rvalid=1 and drop_cnt=0 → DONE. rdata is latched into ld_buf and also bypassed to the outputs in the same cycle.
  - DONE holds until the register captures or bubbles.
- mem_stall_req = (state==WAIT) and not (rvalid and drop_cnt==0).
- Discarded responses: flush or bubble while in WAIT increments drop_cnt, saturating at 2^DROP_W−1. While drop_cnt>0, each rvalid decrements it and is ignored. Increment and decrement in the same cycle leave it unchanged.
- Alignment:
  - Byte offset is result[1:0] (DATA_W=32) or result[2:0] (DATA_W=64).
  - Select the lane, shifted right by offset×8, then extend to DATA_W per ex_ld_signed.
  - Misaligned: half at an odd offset, word with offset not a multiple of 4, dword with offset≠0, or size 11 when DATA_W=32.
  - When misaligned: mem_misalign=1, rf_we forced to 0, and the FSM still waits for the response.
- rf_wdata is the aligned load data for loads, otherwise result.
- Effective rf_we = rf_we and not misaligned and not (state==WAIT and no usable rvalid).
- mem_to_wb_bus.valid = held valid and not mem_stall_req.
- mem_to_id uses the effective rf_we.

## Timing
- All outputs are 0 after reset, except mem_to_wb_bus and mem_to_id, which are derived from a zero register: all fields 0.
- Non-load instructions: 1-cycle latency EX→WB bus; the same fields combinationally on mem_to_id.
- Loads: rvalid is legal from the first cycle in MEM. Latency = 1 + response wait cycles.
- Reset mid-WAIT: FSM goes to IDLE and drop_cnt to 0. Responses in flight are the SRAM controller's responsibility.

## Structure
- Shared package/defines: stall bit indices, Stop/NoStop, ld_size encodings, bus widths derived from parameters.
- One sub-module, ld_align: purely combinational lane select, extension and misalign detection.

## Test plan
- ALU op: result 0x0000_1234, waddr 5, no stall → next cycle WB bus = {1, pc, 1, 5, 0x1234}; mem_to_id matches.
- LB signed at offset 3, rdata 0x80AA_BBCC, rvalid 2 cycles late → mem_stall_req high 2 cycles; wdata 0xFFFF_FF80; forwarding rf_we=0 until rvalid.
- LHU at offset 2, rdata 0x8001_0000, rvalid immediate → wdata 0x0000_8001; no stall cycle.
- LW at offset 2 → mem_misalign=1; rf_we=0 on both buses.
- Flush during WAIT, then a new LW captured; first rvalid 0xDEAD_BEEF, second 0x0000_0042 → first ignored (drop_cnt 1→0); wdata 0x42.
- stall[3]=1, stall[4]=1 during DONE → held data is stable; the async rst pulse clears everything without a clock edge.
